// File: rtl/wb_pkg.sv
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared widths and the writeback request type for the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module   : wb_fifo
// Brief    : In-order sync FIFO of writeback requests; exposes per-slot
//            address/valid so the top can answer hazard queries.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  wb_req_t                 push_req,
    input  logic                    pop,
    output wb_req_t                 head,
    output logic                    full,
    output logic                    empty,
    output logic [DEPTH*REG_AW-1:0] entry_addr,
    output logic [DEPTH-1:0]        entry_valid
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    wb_req_t            r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == (c_PTR_W+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: slot validity is derived from the count.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_req;
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            logic [c_PTR_W-1:0] w_off;
            assign w_off          = c_PTR_W'(i) - r_rd_ptr;
            assign entry_valid[i] = ({1'b0, w_off} < r_count);
            assign entry_addr[i*REG_AW +: REG_AW] = r_mem[i].addr;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module   : wb_arbiter
// Brief    : Merges ALU and long-latency writebacks onto the single reg_file
//            write port, with starvation relief and pending-write reporting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_wr_en,
    input  logic [REG_AW-1:0] alu_waddr,
    input  logic [XLEN-1:0]   alu_wdata,
    output logic              alu_stall,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [REG_AW-1:0] lu_waddr,
    input  logic [XLEN-1:0]   lu_wdata,
    output logic              reg_wr,
    output logic [REG_AW-1:0] waddr,
    output logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] query1,
    input  logic [REG_AW-1:0] query2,
    output logic              pend1,
    output logic              pend2
);

    localparam int c_SC_W = $clog2(STARVE_MAX + 1);

    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_alu_live;
    wb_req_t                 w_head;
    wb_req_t                 w_lu_req;
    logic [DEPTH*REG_AW-1:0] w_entry_addr;
    logic [DEPTH-1:0]        w_entry_valid;
    logic [DEPTH-1:0]        w_hit1;
    logic [DEPTH-1:0]        w_hit2;

    logic [c_SC_W-1:0]       r_starve;
    logic                    r_reg_wr;
    logic [REG_AW-1:0]       r_waddr;
    logic [XLEN-1:0]         r_wdata;

    assign lu_ready   = !rst && !w_full;
    // Writes to x0 are acknowledged but never stored.
    assign w_push     = lu_valid && lu_ready && (lu_waddr != '0);
    assign w_lu_req   = '{addr: lu_waddr, data: lu_wdata};

    assign alu_stall  = (r_starve == c_SC_W'(STARVE_MAX)) && !w_empty;
    assign w_alu_live = alu_wr_en && (alu_waddr != '0) && !alu_stall;
    assign w_pop      = !w_empty && !w_alu_live;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (w_push),
        .push_req    (w_lu_req),
        .pop         (w_pop),
        .head        (w_head),
        .full        (w_full),
        .empty       (w_empty),
        .entry_addr  (w_entry_addr),
        .entry_valid (w_entry_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
            r_reg_wr <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            if (w_alu_live) begin
                r_reg_wr <= 1'b1;
                r_waddr  <= alu_waddr;
                r_wdata  <= alu_wdata;
                if (!w_empty) r_starve <= r_starve + 1'b1;
            end else if (w_pop) begin
                r_reg_wr <= 1'b1;
                r_waddr  <= w_head.addr;
                r_wdata  <= w_head.data;
                r_starve <= '0;
            end else begin
                r_reg_wr <= 1'b0;
            end
        end
    end

    assign reg_wr = r_reg_wr;
    assign waddr  = r_waddr;
    assign wdata  = r_wdata;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_match
            assign w_hit1[i] = w_entry_valid[i] && (w_entry_addr[i*REG_AW +: REG_AW] == query1);
            assign w_hit2[i] = w_entry_valid[i] && (w_entry_addr[i*REG_AW +: REG_AW] == query2);
        end
    endgenerate

    // The output stage counts as pending until reg_file has absorbed it.
    assign pend1 = (query1 != '0) && ((|w_hit1) || (r_reg_wr && (r_waddr == query1)));
    assign pend2 = (query2 != '0) && ((|w_hit2) || (r_reg_wr && (r_waddr == query2)));

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed self-checking bench for wb_arbiter with a reg_file model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_wr_en;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        alu_stall;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        reg_wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  query1;
    logic [4:0]  query2;
    logic        pend1;
    logic        pend2;

    logic [31:0] reg_mem [32];

    int n_pass;
    int n_total;

    wb_arbiter #(
        .DEPTH      (4),
        .STARVE_MAX (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_wr_en (alu_wr_en),
        .alu_waddr (alu_waddr),
        .alu_wdata (alu_wdata),
        .alu_stall (alu_stall),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_waddr  (lu_waddr),
        .lu_wdata  (lu_wdata),
        .reg_wr    (reg_wr),
        .waddr     (waddr),
        .wdata     (wdata),
        .query1    (query1),
        .query2    (query2),
        .pend1     (pend1),
        .pend2     (pend2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reg_file write port model
    always @(posedge clk) begin
        if (reg_wr) reg_mem[waddr] <= wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        alu_wr_en = 1'b0;
        alu_waddr = '0;
        alu_wdata = '0;
        lu_valid  = 1'b0;
        lu_waddr  = '0;
        lu_wdata  = '0;
        query1    = 5'd5;
        query2    = 5'd8;
        for (int i = 0; i < 32; i++) reg_mem[i] = '0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_reset", 32'(lu_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_reg_wr", 32'(reg_wr), 32'd0);
        chk("rst_waddr",  32'(waddr),  32'd0);
        chk("rst_wdata",  wdata,       32'd0);
        chk("rst_ready",  32'(lu_ready), 32'd1);
        chk("rst_pend1",  32'(pend1),  32'd0);
        chk("rst_pend2",  32'(pend2),  32'd0);

        // ALU only
        step();
        alu_wr_en = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'hDEADBEEF;
        chk("alu_no_stall", 32'(alu_stall), 32'd0);
        step();
        alu_wr_en = 1'b0;
        chk("alu_reg_wr", 32'(reg_wr), 32'd1);
        chk("alu_waddr",  32'(waddr),  32'd5);
        chk("alu_wdata",  wdata,       32'hDEADBEEF);
        chk("alu_pend1",  32'(pend1),  32'd1);
        step();
        chk("alu_regfile_x5", reg_mem[5], 32'hDEADBEEF);
        chk("alu_idle_reg_wr", 32'(reg_wr), 32'd0);

        // Queue then drain
        query1 = 5'd8;
        lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'd1;
        step();
        chk("q_first_idle", 32'(reg_wr), 32'd0);
        lu_waddr = 5'd8; lu_wdata = 32'd2;
        step();
        chk("q_w7_addr", 32'(waddr), 32'd7);
        chk("q_w7_data", wdata, 32'd1);
        chk("q_pend8_fifo", 32'(pend1), 32'd1);
        lu_waddr = 5'd9; lu_wdata = 32'd3;
        step();
        lu_valid = 1'b0;
        chk("q_w8_addr", 32'(waddr), 32'd8);
        chk("q_w8_data", wdata, 32'd2);
        chk("q_pend8_out", 32'(pend1), 32'd1);
        step();
        chk("q_w9_reg_wr", 32'(reg_wr), 32'd1);
        chk("q_w9_addr", 32'(waddr), 32'd9);
        chk("q_w9_data", wdata, 32'd3);
        chk("q_pend8_gone", 32'(pend1), 32'd0);
        step();
        chk("q_drained", 32'(reg_wr), 32'd0);

        // Fill while ALU writes every cycle
        alu_wr_en = 1'b1;
        lu_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            alu_waddr = 5'(10 + k); alu_wdata = 32'hA0 + 32'(k);
            lu_waddr  = 5'(20 + k); lu_wdata  = 32'h100 + 32'(k);
            #1;
            chk($sformatf("fill_ready_%0d", k), 32'(lu_ready), 32'd1);
            chk($sformatf("fill_stall_%0d", k), 32'(alu_stall), 32'd0);
            step();
            chk($sformatf("fill_alu_addr_%0d", k), 32'(waddr), 32'(10 + k));
        end
        alu_waddr = 5'd14; alu_wdata = 32'hA4;
        lu_waddr  = 5'd24; lu_wdata  = 32'h104;
        #1;
        chk("full_ready", 32'(lu_ready), 32'd0);
        chk("starve_stall", 32'(alu_stall), 32'd1);
        step();
        chk("starve_head_addr", 32'(waddr), 32'd20);
        chk("starve_head_data", wdata, 32'h100);
        chk("starve_cleared", 32'(alu_stall), 32'd0);
        chk("after_pop_ready", 32'(lu_ready), 32'd1);
        step();
        alu_wr_en = 1'b0;
        lu_valid  = 1'b0;
        chk("held_alu_addr", 32'(waddr), 32'd14);
        chk("held_alu_data", wdata, 32'hA4);
        for (int k = 1; k < 5; k++) begin
            step();
            chk($sformatf("drain_addr_%0d", k), 32'(waddr), 32'(20 + k));
            chk($sformatf("drain_data_%0d", k), wdata, 32'h100 + 32'(k));
        end
        step();
        chk("fill_drained", 32'(reg_wr), 32'd0);

        // x0 filter
        query1 = 5'd0; query2 = 5'd0;
        lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'h55;
        alu_wr_en = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'h66;
        #1;
        chk("x0_ready", 32'(lu_ready), 32'd1);
        chk("x0_pend1", 32'(pend1), 32'd0);
        step();
        lu_valid = 1'b0; alu_wr_en = 1'b0;
        chk("x0_reg_wr_a", 32'(reg_wr), 32'd0);
        step();
        chk("x0_reg_wr_b", 32'(reg_wr), 32'd0);
        chk("x0_pend2", 32'(pend2), 32'd0);

        // Async reset with queued entries and a live output stage
        alu_wr_en = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h33;
        lu_valid  = 1'b1; lu_waddr  = 5'd12; lu_wdata = 32'hC;
        step();
        alu_waddr = 5'd4; alu_wdata = 32'h44;
        lu_waddr  = 5'd13; lu_wdata = 32'hD;
        step();
        alu_wr_en = 1'b0; lu_valid = 1'b0;
        query1 = 5'd13; query2 = 5'd4;
        #1;
        chk("pre_rst_reg_wr", 32'(reg_wr), 32'd1);
        chk("pre_rst_pend13", 32'(pend1), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_reg_wr", 32'(reg_wr), 32'd0);
        chk("arst_waddr",  32'(waddr),  32'd0);
        chk("arst_wdata",  wdata,       32'd0);
        chk("arst_pend1",  32'(pend1),  32'd0);
        chk("arst_ready",  32'(lu_ready), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_pend13", 32'(pend1), 32'd0);
        step();
        chk("post_rst_no_write", 32'(reg_wr), 32'd0);
        chk("post_rst_regfile_x4", reg_mem[4], 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
